// File: rtl/aes_ahb_pkg.sv
// Shared definitions for the AES accelerator AHB-Lite slave front end:
// register offsets, STATUS bit positions and the bus-side state encoding.
package aes_ahb_pkg;

   // Register offsets, decoded from haddr[3:2]
   localparam logic [1:0] CTRL_ADDR    = 2'd0;
   localparam logic [1:0] STATUS_ADDR  = 2'd1;
   localparam logic [1:0] DATAIN_ADDR  = 2'd2;
   localparam logic [1:0] DATAOUT_ADDR = 2'd3;

   // STATUS register bit positions
   localparam int ST_KEY_DONE = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_VALID = 2;
   localparam int ST_OVF      = 3;
   localparam int ST_TX_CNT   = 4;   // bits [7:4]

   // The only transfer size the slave supports (32-bit word)
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Bus-side transfer state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } bus_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO. Pointers wrap modulo DEPTH (power of two).
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop happens in the same cycle, because the pop frees the slot first.
module word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy count
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AES accelerator. Decodes CPU register
// accesses into controller controls and buffers words in both directions.
// Optional build macro AHB_IF_WAIT_EN: full/empty DATA_IN/DATA_OUT accesses
// are held with wait states (capped at 255 cycles) instead of erroring.
module ahb_slave_if
   import aes_ahb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              hsel,
   input  logic [3:0]        haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic              hready,
   input  logic [DATA_W-1:0] hwdata,
   output logic [DATA_W-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp,
   output logic              start,
   output logic              data_type,
   output logic              enc_dec,
   output logic              data_received,
   output logic [DATA_W-1:0] rx_data,
   input  logic              ahb_mode,
   input  logic              ahb_shift_en,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              done_chg_key
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   bus_state_t  state, state_nxt;
   logic [1:0]  addr_q;
   logic        write_q;
   logic [2:0]  size_q;
   logic        accept, take_addr, complete;
   logic        hard_err, rx_block, tx_block, err_now, wait_now;
   logic        key_done, ovf;
   logic        core_pop_req, core_push_req;
   logic        wr_ctrl, rx_push, tx_pop, st_read;
   logic        rx_full, rx_empty, tx_full, tx_empty;
   logic [CW-1:0]     rx_count, tx_count;
   logic [DATA_W-1:0] tx_head;
   logic        unused_bits;

   assign unused_bits = ^{haddr[1:0], htrans[0], rx_count};

   assign accept        = hsel & hready & htrans[1];
   assign core_pop_req  = ahb_shift_en & ~ahb_mode;
   assign core_push_req = ahb_shift_en & ahb_mode;

   // Classification of the transfer sitting in its data phase. A DATA_IN
   // write to a full FIFO is fine if the core pops in the same cycle.
   assign hard_err = (size_q != HSIZE_WORD) ||
                     (write_q && (addr_q == STATUS_ADDR || addr_q == DATAOUT_ADDR));
   assign rx_block = write_q && (addr_q == DATAIN_ADDR) && rx_full && !core_pop_req;
   assign tx_block = !write_q && (addr_q == DATAOUT_ADDR) && tx_empty;

`ifdef AHB_IF_WAIT_EN
   logic [7:0] stall_cnt;
   logic       stall_req, stall_cap;

   assign stall_req = !hard_err && (rx_block || tx_block);
   assign stall_cap = (stall_cnt == 8'd255);
   assign err_now   = hard_err || (stall_req && stall_cap);
   assign wait_now  = stall_req && !stall_cap;

   // Count consecutive wait cycles of the current data phase
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                         stall_cnt <= '0;
      else if (state == DATA && wait_now) stall_cnt <= stall_cnt + 8'd1;
      else                                stall_cnt <= '0;
   end
`else
   assign err_now  = hard_err || rx_block || tx_block;
   assign wait_now = 1'b0;
`endif

   // Bus state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs. The data phase of an errored transfer
   // is held low one cycle, then the two-cycle ERROR response follows.
   always_comb begin
      state_nxt = state;
      hreadyout = 1'b1;
      hresp     = 1'b0;
      complete  = 1'b0;
      take_addr = 1'b0;
      case (state)
         IDLE: begin
            take_addr = accept;
            if (accept) state_nxt = DATA;
         end
         DATA: begin
            if (err_now) begin
               hreadyout = 1'b0;
               state_nxt = ERR1;
            end else if (wait_now) begin
               hreadyout = 1'b0;
            end else begin
               complete  = 1'b1;
               take_addr = accept;
               state_nxt = accept ? DATA : IDLE;
            end
         end
         ERR1: begin
            hresp     = 1'b1;
            hreadyout = 1'b0;
            state_nxt = ERR2;
         end
         ERR2: begin
            hresp     = 1'b1;
            take_addr = accept;
            state_nxt = accept ? DATA : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address-phase capture into the data phase
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         addr_q  <= CTRL_ADDR;
         write_q <= 1'b0;
         size_q  <= HSIZE_WORD;
      end else if (take_addr) begin
         addr_q  <= haddr[3:2];
         write_q <= hwrite;
         size_q  <= hsize;
      end
   end

   assign wr_ctrl = complete &  write_q & (addr_q == CTRL_ADDR);
   assign rx_push = complete &  write_q & (addr_q == DATAIN_ADDR);
   assign tx_pop  = complete & ~write_q & (addr_q == DATAOUT_ADDR);
   assign st_read = complete & ~write_q & (addr_q == STATUS_ADDR);

   // Control register, start pulse and sticky status bits. A new event wins
   // over the clear-on-read so it is never lost.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         start     <= 1'b0;
         data_type <= 1'b0;
         enc_dec   <= 1'b0;
         key_done  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         start <= wr_ctrl & hwdata[0];
         if (wr_ctrl) begin
            data_type <= hwdata[1];
            enc_dec   <= hwdata[2];
         end
         if (done_chg_key) key_done <= 1'b1;
         else if (st_read) key_done <= 1'b0;
         if ((core_pop_req & rx_empty) | (core_push_req & tx_full & ~tx_pop)) ovf <= 1'b1;
         else if (st_read)                                                    ovf <= 1'b0;
      end
   end

   // Read data, driven only during a read data phase
   always_comb begin
      hrdata = '0;
      if (state == DATA && !write_q) begin
         case (addr_q)
            CTRL_ADDR: begin
               hrdata[1] = data_type;
               hrdata[2] = enc_dec;
            end
            STATUS_ADDR: begin
               hrdata[ST_KEY_DONE]    = key_done;
               hrdata[ST_RX_FULL]     = rx_full;
               hrdata[ST_TX_VALID]    = ~tx_empty;
               hrdata[ST_OVF]         = ovf;
               hrdata[ST_TX_CNT +: 4] = 4'(tx_count);
            end
            DATAOUT_ADDR: hrdata = tx_head;
            default:      hrdata = '0;
         endcase
      end
   end

   word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (rx_push),
      .pop   (core_pop_req),
      .din   (hwdata),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count),
      .head  (rx_data)
   );

   word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
      .clk   (clk),
      .n_rst (n_rst),
      .push  (core_push_req),
      .pop   (tx_pop),
      .din   (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .head  (tx_head)
   );

   assign data_received = ~rx_empty;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed, self-checking bench for ahb_slave_if: bus transfer tasks, core
// shift tasks and expected-value queues for read data, rx words and tx words.
module tb_ahb_slave_if;
   import aes_ahb_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          hsel;
   logic [3:0]    haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic          hready;
   logic [DW-1:0] hwdata;
   logic [DW-1:0] hrdata;
   logic          hreadyout;
   logic          hresp;
   logic          start;
   logic          data_type;
   logic          enc_dec;
   logic          data_received;
   logic [DW-1:0] rx_data;
   logic          ahb_mode;
   logic          ahb_shift_en;
   logic [DW-1:0] tx_data;
   logic          done_chg_key;

   // Clock and single-slave bus ready feedback
   always #5 clk = ~clk;
   assign hready = hreadyout;

   ahb_slave_if #(.FIFO_DEPTH(4), .DATA_W(DW)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .hsel          (hsel),
      .haddr         (haddr),
      .htrans        (htrans),
      .hwrite        (hwrite),
      .hsize         (hsize),
      .hready        (hready),
      .hwdata        (hwdata),
      .hrdata        (hrdata),
      .hreadyout     (hreadyout),
      .hresp         (hresp),
      .start         (start),
      .data_type     (data_type),
      .enc_dec       (enc_dec),
      .data_received (data_received),
      .rx_data       (rx_data),
      .ahb_mode      (ahb_mode),
      .ahb_shift_en  (ahb_shift_en),
      .tx_data       (tx_data),
      .done_chg_key  (done_chg_key)
   );

   int n_checks  = 0;
   int n_pass    = 0;
   int start_cnt = 0;
   logic [DW-1:0] rd_exp_q[$];
   logic [DW-1:0] rx_exp_q[$];
   logic [DW-1:0] tx_exp_q[$];
   logic [DW-1:0] rd_w;
   int            rn, rl;

   // Count cycles with start high
   always @(negedge clk) if (n_rst === 1'b1 && start === 1'b1) start_cnt++;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One non-pipelined transfer; returns read data and hresp statistics
   task automatic bus_xfer(input logic wr, input logic [1:0] a, input logic [2:0] sz,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                           output int resp_n, output int resp_low_n);
      logic done;
      done = 1'b0;
      resp_n = 0;
      resp_low_n = 0;
      rd = '0;
      @(posedge clk); #1;
      hsel = 1'b1; haddr = {a, 2'b00}; htrans = 2'b10; hwrite = wr; hsize = sz;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (hresp) begin
            resp_n++;
            if (!hreadyout) resp_low_n++;
         end
         if (hreadyout) begin
            done = 1'b1;
            rd = hrdata;
         end
      end
      check("xfer_done", 32'(done), 32'd1);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d, input string tag);
      logic [DW-1:0] rd;
      int r_n, r_l;
      bus_xfer(1'b1, a, 3'b010, d, rd, r_n, r_l);
      check(tag, 32'(r_n), 32'd0);
   endtask

   task automatic bus_read(input logic [1:0] a, input string tag);
      logic [DW-1:0] rd;
      int r_n, r_l;
      bus_xfer(1'b0, a, 3'b010, '0, rd, r_n, r_l);
      check({tag, "_resp"}, 32'(r_n), 32'd0);
      check(tag, rd, rd_exp_q.pop_front());
   endtask

   task automatic core_pop(input string tag);
      @(posedge clk); #1;
      ahb_shift_en = 1'b1; ahb_mode = 1'b0;
      @(negedge clk);
      check(tag, rx_data, rx_exp_q.pop_front());
      @(posedge clk); #1;
      ahb_shift_en = 1'b0;
   endtask

   task automatic core_push(input logic [DW-1:0] d);
      tx_exp_q.push_back(d);
      @(posedge clk); #1;
      ahb_shift_en = 1'b1; ahb_mode = 1'b1; tx_data = d;
      @(posedge clk); #1;
      ahb_shift_en = 1'b0;
   endtask

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_rst = 1'b0; hsel = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0;
      hsize = 3'b010; hwdata = '0; ahb_mode = 1'b0; ahb_shift_en = 1'b0;
      tx_data = '0; done_chg_key = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_hreadyout", 32'(hreadyout), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_ctrl_outs", 32'({start, data_type, enc_dec, data_received}), 32'd0);
      check("rst_rx_data", rx_data, 32'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;

      // CTRL write: single start pulse, mode bits, readback without start
      start_cnt = 0;
      bus_write(CTRL_ADDR, 32'h7, "ctrl_wr");
      repeat (4) @(negedge clk);
      check("start_cycles", 32'(start_cnt), 32'd1);
      check("data_type", 32'(data_type), 32'd1);
      check("enc_dec", 32'(enc_dec), 32'd1);
      rd_exp_q.push_back(32'h6);
      bus_read(CTRL_ADDR, "ctrl_rd");

      // Wrong hsize: ERROR and no side effect
      bus_xfer(1'b1, CTRL_ADDR, 3'b000, 32'h0, rd_w, rn, rl);
      check("hsize_err_resp", 32'(rn), 32'd2);
      check("hsize_no_effect", 32'(data_type), 32'd1);

      // Fill input FIFO
      for (int k = 1; k <= 4; k++) begin
         rx_exp_q.push_back(32'h11111111 * k);
         bus_write(DATAIN_ADDR, 32'h11111111 * k, "din_wr");
      end
      check("data_received_full", 32'(data_received), 32'd1);
      rd_exp_q.push_back(32'h2);
      bus_read(STATUS_ADDR, "status_rx_full");

      // Fifth write while full
`ifdef AHB_IF_WAIT_EN
      fork
         bus_xfer(1'b1, DATAIN_ADDR, 3'b010, 32'h55555555, rd_w, rn, rl);
         begin
            repeat (6) @(posedge clk);
            #1;
            ahb_shift_en = 1'b1; ahb_mode = 1'b0;
            @(negedge clk);
            check("rx_pop_during_stall", rx_data, rx_exp_q.pop_front());
            @(posedge clk); #1;
            ahb_shift_en = 1'b0;
         end
      join
      check("stall_write_resp", 32'(rn), 32'd0);
      rx_exp_q.push_back(32'h55555555);
`else
      bus_xfer(1'b1, DATAIN_ADDR, 3'b010, 32'h55555555, rd_w, rn, rl);
      check("full_write_resp_cycles", 32'(rn), 32'd2);
      check("full_write_resp_low", 32'(rl), 32'd1);
`endif

      // Drain input FIFO in order
      for (int k = 0; k < 4; k++) core_pop("rx_order");
      check("data_received_empty", 32'(data_received), 32'd0);

      // Pop on empty sets ovf, cleared by the STATUS read
      @(posedge clk); #1;
      ahb_shift_en = 1'b1; ahb_mode = 1'b0;
      @(posedge clk); #1;
      ahb_shift_en = 1'b0;
      rd_exp_q.push_back(32'h8);
      bus_read(STATUS_ADDR, "status_ovf");
      rd_exp_q.push_back(32'h0);
      bus_read(STATUS_ADDR, "status_ovf_clr");

      // Output FIFO: two words, status, ordered reads, read on empty
      core_push(32'hA5A5A5A5);
      core_push(32'h5A5A5A5A);
      rd_exp_q.push_back(32'h24);
      bus_read(STATUS_ADDR, "status_tx");
      rd_exp_q.push_back(tx_exp_q.pop_front());
      bus_read(DATAOUT_ADDR, "dout_rd0");
      rd_exp_q.push_back(tx_exp_q.pop_front());
      bus_read(DATAOUT_ADDR, "dout_rd1");
      bus_xfer(1'b0, DATAOUT_ADDR, 3'b010, 32'h0, rd_w, rn, rl);
      check("dout_empty_resp", 32'(rn), 32'd2);

      // key_done sticky, cleared by read
      @(posedge clk); #1;
      done_chg_key = 1'b1;
      @(posedge clk); #1;
      done_chg_key = 1'b0;
      rd_exp_q.push_back(32'h1);
      bus_read(STATUS_ADDR, "status_key");
      rd_exp_q.push_back(32'h0);
      bus_read(STATUS_ADDR, "status_key_clr");

      // Bus push and core pop together on a full input FIFO
      for (int k = 1; k <= 4; k++) begin
         rx_exp_q.push_back(32'hC0DE0000 + k);
         bus_write(DATAIN_ADDR, 32'hC0DE0000 + k, "din_refill");
      end
      rx_exp_q.push_back(32'hC0DE0005);
      fork
         bus_xfer(1'b1, DATAIN_ADDR, 3'b010, 32'hC0DE0005, rd_w, rn, rl);
         begin
            @(posedge clk);
            @(posedge clk); #1;
            ahb_shift_en = 1'b1; ahb_mode = 1'b0;
            @(negedge clk);
            check("coincide_pop", rx_data, rx_exp_q.pop_front());
            @(posedge clk); #1;
            ahb_shift_en = 1'b0;
         end
      join
      check("coincide_resp", 32'(rn), 32'd0);
      rd_exp_q.push_back(32'h2);
      bus_read(STATUS_ADDR, "status_still_full");
      for (int k = 0; k < 4; k++) core_pop("rx_after_coincide");
      check("data_received_drained", 32'(data_received), 32'd0);

      // Reset in the middle of an errored/stalled DATA_OUT read
      bus_write(DATAIN_ADDR, 32'hDEAD0001, "din_pre_rst");
      bus_write(CTRL_ADDR, 32'h6, "ctrl_pre_rst");
      @(posedge clk); #1;
      hsel = 1'b1; haddr = {DATAOUT_ADDR, 2'b00}; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(posedge clk); #1;
      check("busy_before_rst", 32'(hreadyout), 32'd0);
      n_rst = 1'b0;
      #1;
      check("midrst_hreadyout", 32'(hreadyout), 32'd1);
      check("midrst_hresp", 32'(hresp), 32'd0);
      check("midrst_ctrl_outs", 32'({start, data_type, enc_dec, data_received}), 32'd0);
      check("midrst_rx_data", rx_data, 32'd0);
      check("midrst_hrdata", hrdata, 32'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      rd_exp_q.push_back(32'h0);
      bus_read(STATUS_ADDR, "status_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-Lite slave front end of the AES accelerator. Bus side: CPU bus. Core side: the main AES controller and the key/data datapath.
- Converts CPU register accesses into the controller's start, data_type, enc_dec and data_received inputs.
- Buffers 32-bit words in both directions: input FIFO to the datapath, output FIFO from the datapath.
- Consumes the controller's ahb_mode/ahb_shift_en shift requests and its done_chg_key pulse.

Parameters:
- FIFO_DEPTH, 4: words per direction; power of two, at least 2; 4 words = one 128-bit AES block.
- DATA_W, 32: HWDATA/HRDATA and word width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  4  byte address; bits [3:2] decoded
- htrans  in  2  transfer type; bit1 = NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  must be 3'b010; other sizes get an ERROR response
- hready  in  1  bus-wide ready
- hwdata  in  DATA_W  write data, valid in data phase
- hrdata  out  DATA_W  read data
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- start  out  1  one-cycle pulse to controller
- data_type  out  1  1 = key load, 0 = payload
- enc_dec  out  1  0 = encrypt, 1 = decrypt
- data_received  out  1  input FIFO not empty
- rx_data  out  DATA_W  input FIFO head
- ahb_mode  in  1  0 = pop rx, 1 = push tx
- ahb_shift_en  in  1  shift request from controller
- tx_data  in  DATA_W  word from datapath, pushed when ahb_shift_en & ahb_mode
- done_chg_key  in  1  key stored pulse

Behaviour:
- Register map, haddr[3:2]:
  - 0 CTRL, RW: bit0 start (write-1 pulses, reads 0); bit1 data_type; bit2 enc_dec.
  - 1 STATUS, RO: bit0 key_done (sticky); bit1 rx_full; bit2 tx_valid; bit3 ovf (sticky); bits[7:4] tx_count.
  - 2 DATA_IN, WO: pushes one word to the input FIFO.
  - 3 DATA_OUT, RO: pops one word from the output FIFO.
- Any read of STATUS clears the key_done and ovf sticky bits after the read.
- Address phase accepted when hsel & hready & htrans[1]. haddr, hwrite and hsize are registered into the data phase.
- Bus state machine, states IDLE, DATA, ERR1, ERR2:
  - IDLE -> DATA on an accepted transfer.
  - DATA completes the transfer and returns to IDLE, or stays in DATA on a back-to-back accept.
  - DATA -> ERR1 on an error condition. Error conditions: hsize != 010; write to STATUS or DATA_OUT; write DATA_IN with input FIFO full; read DATA_OUT with output FIFO empty.
  - ERR1 drives hresp=1, hreadyout=0. ERR2 drives hresp=1, hreadyout=1, then IDLE.
  - An errored transfer has no side effects.
- Zero wait states on non-error transfers.
- hrdata is combinational from the registered address and is valid in the data phase. The DATA_OUT pop happens on the data-phase edge.
- CTRL write: data_type and enc_dec update on the data-phase edge. A start pulse is asserted the cycle after the data-phase edge, for exactly one cycle.
- Core side:
  - ahb_shift_en & !ahb_mode pops the input FIFO. A pop on an empty FIFO is ignored and sets ovf.
  - ahb_shift_en & ahb_mode pushes tx_data. A push on a full FIFO drops the word and sets ovf.
  - done_chg_key sets key_done.
- Simultaneous push and pop on one FIFO in the same cycle: count unchanged. A bus push and a core pop may coincide even when the FIFO is full, since the pop frees the slot first.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Reset values:
  - Outputs: hrdata=0, hreadyout=1, hresp=0, start=0, data_type=0, enc_dec=0, data_received=0, rx_data=0.
  - Internal: FIFOs empty, sticky bits cleared, state IDLE.
  - Reset mid-transfer abandons the transfer.

Optional Feature:
- Macro AHB_IF_WAIT_EN.
- Defined: full/empty DATA_IN/DATA_OUT accesses are no longer errors. The slave holds hreadyout=0 in DATA until space or data exists, then completes. A STALL counter caps this at 255 cycles, after which the ERROR sequence is issued.
- Undefined: the ERROR response above applies.

Decomposition:
- Package aes_ahb_pkg holds:
  - register offset constants CTRL_ADDR, STATUS_ADDR, DATAIN_ADDR, DATAOUT_ADDR;
  - the STATUS bit index constants;
  - the bus state enum typedef.
- Sub-module word_fifo (parameterised DEPTH/WIDTH; push, pop, full, empty, count, head), instantiated twice.

Test Plan:
- Write CTRL=0x7 -> start high exactly 1 cycle, data_type=1, enc_dec=1; a CTRL read then returns 0x6.
- Four DATA_IN writes 0x11111111..0x44444444 -> data_received=1, rx_full=1. Controller shifts 4x with ahb_mode=0 -> rx_data sequence in order, data_received=0.
- Fifth DATA_IN write while full -> hresp=1 for 2 cycles, hreadyout low in the first. FIFO contents unchanged. With AHB_IF_WAIT_EN: stall until a core pop, then accept.
- Core pushes 0xA5A5A5A5, 0x5A5A5A5A with ahb_mode=1 -> STATUS tx_count=2, tx_valid=1. Two DATA_OUT reads return the words in order; a third read errors.
- done_chg_key pulse -> STATUS bit0=1; the next STATUS read returns bit0=1 and the following read returns 0.
- Bus push and core pop in the same cycle on a full input FIFO -> no error, count stays 4. Assert n_rst mid-burst -> all outputs at reset values immediately.
